// File: rtl/mux2_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Two-requester round-robin arbiter that drives the select of a
//            shared 2:1 mux, registers the mux output with a valid strobe,
//            and bounds how long one requester may hold the datapath while
//            the other is waiting.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  output logic             GNT0,
  output logic             GNT1,
  output logic             SEL,
  output logic [WIDTH-1:0] Y,
  output logic             VALID
);

  // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
  localparam int            HOLD_W    = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]        state_q,      state_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic              last_owner_q, last_owner_d;
  logic [WIDTH-1:0]  y_q,          y_d;
  logic              valid_q,      valid_d;

  logic              granted;

  assign granted = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);

  // Grant state machine: next owner, hold-count tracking and fairness memory.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ0 && REQ1) begin
          // Contention from idle goes to whoever did not own it last.
          state_d = last_owner_q ? ST_GRANT0 : ST_GRANT1;
        end else if (REQ0) begin
          state_d = ST_GRANT0;
        end else if (REQ1) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT0: begin
        if (!REQ0) begin
          // Release hands straight over with no idle bubble.
          state_d = REQ1 ? ST_GRANT1 : ST_IDLE;
        end else if (REQ1 && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GRANT1;
        end
      end
      ST_GRANT1: begin
        if (!REQ1) begin
          state_d = REQ0 ? ST_GRANT0 : ST_IDLE;
        end else if (REQ0 && (hold_cnt_q == HOLD_LAST)) begin
          state_d = ST_GRANT0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The counter saturates so an uncontended owner is preempted at once
    // when the other side finally requests.
    if (state_d != state_q) begin
      hold_cnt_d = '0;
    end else if (granted && (hold_cnt_q != HOLD_LAST)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    if (state_d == ST_GRANT0) begin
      last_owner_d = 1'b0;
    end else if (state_d == ST_GRANT1) begin
      last_owner_d = 1'b1;
    end
  end

  // Datapath: capture the granted requester's data; hold Y otherwise so the
  // idle requester's inputs never reach the output.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (granted) begin
      y_d     = (state_q == ST_GRANT1) ? D1 : D0;
      valid_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;
      y_q          <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
      y_q          <= y_d;
      valid_q      <= valid_d;
    end
  end

  assign GNT0  = (state_q == ST_GRANT0);
  assign GNT1  = (state_q == ST_GRANT1);
  assign SEL   = GNT1;
  assign Y     = y_q;
  assign VALID = valid_q;

endmodule
`default_nettype wire
